// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: decodes one MIPS-subset instruction per cycle, forwards
// operands from EX/MEM and MEM/WB, and inserts a bubble on load-use hazards.

// One forwarding mux per source register. EX/MEM is the younger result, so it
// takes priority. Register 0 is never forwarded.
module operand_fwd #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rf_data,
    input  logic          exm_we,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_val,
    input  logic          mwb_we,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_val,
    output logic [DW-1:0] data
);
    always_comb begin
        data = rf_data;
        if (exm_we && exm_rd != '0 && exm_rd == src)
            data = exm_val;
        else if (mwb_we && mwb_rd != '0 && mwb_rd == src)
            data = mwb_val;
    end
endmodule

module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          stall_in,
    input  logic          flush,
    input  logic          exm_we,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_val,
    input  logic          mwb_we,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_val,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic [2:0]    alu_sel,
    output logic [RW-1:0] dest_reg,
    output logic          reg_write,
    output logic          mem_read,
    output logic          mem_write,
    output logic          branch,
    output logic [DW-1:0] store_data
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_SUB = 3'd1;
    localparam logic [2:0] SEL_AND = 3'd2;
    localparam logic [2:0] SEL_OR  = 3'd3;
    localparam logic [2:0] SEL_SLT = 3'd4;
    localparam logic [2:0] SEL_MUL = 3'd5;
    localparam logic [2:0] SEL_DIV = 3'd6;
    localparam logic [2:0] SEL_NOP = 3'd7;

    typedef struct packed {
        logic [2:0]    sel;
        logic [RW-1:0] dest;
        logic          use_imm;
        logic [DW-1:0] imm;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          br;
    } dec_t;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] imm_se;
    logic [DW-1:0] imm_ze;
    logic          reads_rt;
    dec_t          dec;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm_se = {{(DW-16){instr[15]}}, instr[15:0]};
    assign imm_ze = {{(DW-16){1'b0}}, instr[15:0]};

    // Unknown encodings fall through as sel=NOP with every control bit low.
    always_comb begin
        dec = '{sel: SEL_NOP, dest: '0, use_imm: 1'b0, imm: '0,
                rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0};
        case (opcode)
            OP_R: begin
                dec.dest = rd;
                dec.rw   = 1'b1;
                case (funct)
                    6'b100000: dec.sel = SEL_ADD;
                    6'b100010: dec.sel = SEL_SUB;
                    6'b100100: dec.sel = SEL_AND;
                    6'b100101: dec.sel = SEL_OR;
                    6'b101010: dec.sel = SEL_SLT;
                    6'b011000: dec.sel = SEL_MUL;
                    6'b011010: dec.sel = SEL_DIV;
                    default: begin
                        dec.dest = '0;
                        dec.rw   = 1'b0;
                    end
                endcase
            end
            OP_ADDI: dec = '{sel: SEL_ADD, dest: rt, use_imm: 1'b1, imm: imm_se,
                             rw: 1'b1, mr: 1'b0, mw: 1'b0, br: 1'b0};
            OP_SLTI: dec = '{sel: SEL_SLT, dest: rt, use_imm: 1'b1, imm: imm_se,
                             rw: 1'b1, mr: 1'b0, mw: 1'b0, br: 1'b0};
            OP_ANDI: dec = '{sel: SEL_AND, dest: rt, use_imm: 1'b1, imm: imm_ze,
                             rw: 1'b1, mr: 1'b0, mw: 1'b0, br: 1'b0};
            OP_ORI:  dec = '{sel: SEL_OR,  dest: rt, use_imm: 1'b1, imm: imm_ze,
                             rw: 1'b1, mr: 1'b0, mw: 1'b0, br: 1'b0};
            OP_LW:   dec = '{sel: SEL_ADD, dest: rt, use_imm: 1'b1, imm: imm_se,
                             rw: 1'b1, mr: 1'b1, mw: 1'b0, br: 1'b0};
            OP_SW:   dec = '{sel: SEL_ADD, dest: rt, use_imm: 1'b1, imm: imm_se,
                             rw: 1'b0, mr: 1'b0, mw: 1'b1, br: 1'b0};
            OP_BEQ:  dec = '{sel: SEL_SUB, dest: rt, use_imm: 1'b0, imm: '0,
                             rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b1};
            default: ;
        endcase
        if (dec.dest == '0)
            dec.rw = 1'b0;
    end

    // Index 0 forwards rs, index 1 forwards rt.
    logic [1:0][RW-1:0] fwd_src;
    logic [1:0][DW-1:0] fwd_rf;
    logic [1:0][DW-1:0] fwd_data;

    assign fwd_src = {rt, rs};
    assign fwd_rf  = {rt_data, rs_data};

    operand_fwd #(.DW(DW), .RW(RW)) u_fwd [1:0] (
        .src     (fwd_src),
        .rf_data (fwd_rf),
        .exm_we  (exm_we),
        .exm_rd  (exm_rd),
        .exm_val (exm_val),
        .mwb_we  (mwb_we),
        .mwb_rd  (mwb_rd),
        .mwb_val (mwb_val),
        .data    (fwd_data)
    );

    assign reads_rt = (opcode == OP_R) || (opcode == OP_BEQ) || (opcode == OP_SW);

    assign hazard_stall = ex_valid && mem_read && (dest_reg != '0) && in_valid &&
                          ((dest_reg == rs) || ((dest_reg == rt) && reads_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_sel    <= SEL_NOP;
            dest_reg   <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            store_data <= '0;
        end else if (!stall_in) begin
            if (flush || hazard_stall || !in_valid) begin
                ex_valid   <= 1'b0;
                alu_x      <= '0;
                alu_y      <= '0;
                alu_sel    <= SEL_NOP;
                dest_reg   <= '0;
                reg_write  <= 1'b0;
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
                branch     <= 1'b0;
                store_data <= '0;
            end else begin
                ex_valid   <= 1'b1;
                alu_x      <= fwd_data[0];
                alu_y      <= dec.use_imm ? dec.imm : fwd_data[1];
                alu_sel    <= dec.sel;
                dest_reg   <= dec.dest;
                reg_write  <= dec.rw;
                mem_read   <= dec.mr;
                mem_write  <= dec.mw;
                branch     <= dec.br;
                store_data <= fwd_data[1];
            end
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_id_ex_operand_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data, rt_data;
    logic        stall_in, flush;
    logic        exm_we, mwb_we;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_val, mwb_val;
    logic        hazard_stall, ex_valid;
    logic [31:0] alu_x, alu_y, store_data;
    logic [2:0]  alu_sel;
    logic [4:0]  dest_reg;
    logic        reg_write, mem_read, mem_write, branch;

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .stall_in(stall_in), .flush(flush),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_val(exm_val),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_x(alu_x), .alu_y(alu_y),
        .alu_sel(alu_sel), .dest_reg(dest_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .store_data(store_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        logic        v;
        logic [31:0] x, y, sd;
        logic [2:0]  sel;
        logic [4:0]  dest;
        logic        rw, mr, mw, br;
        bit          chk_data, chk_sd;
    } exp_t;

    typedef struct {
        int    due;
        string name;
        logic  val;
    } haz_t;

    exp_t exp_q[$];
    haz_t haz_q[$];
    exp_t last_e;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    localparam logic [31:0] I_ADDI  = 32'h2008FFFB;
    localparam logic [31:0] I_ORI   = 32'h34298001;
    localparam logic [31:0] I_ADDF  = 32'h012B5020;
    localparam logic [31:0] I_SUB0  = 32'h00220022;
    localparam logic [31:0] I_MUL   = 32'h00221818;
    localparam logic [31:0] I_SLTI  = 32'h28438000;
    localparam logic [31:0] I_ANDI  = 32'h3043FFFF;
    localparam logic [31:0] I_BEQ   = 32'h10850010;
    localparam logic [31:0] I_BADF  = 32'h00221801;
    localparam logic [31:0] I_BADOP = 32'hFC000000;
    localparam logic [31:0] I_LW    = 32'h8C280004;
    localparam logic [31:0] I_ADD88 = 32'h01085020;
    localparam logic [31:0] I_ORI8  = 32'h34280001;
    localparam logic [31:0] I_SW    = 32'hAC430008;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 1'b1; instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        stall_in = 1'b0; flush = 1'b0;
        exm_we = 1'b0; exm_rd = 5'd0; exm_val = 32'h0;
        mwb_we = 1'b0; mwb_rd = 5'd0; mwb_val = 32'h0;
    endtask

    task automatic exp_op(input string n, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] sel, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic mw, input logic br);
        exp_t e;
        e.due = cyc + 1; e.name = n; e.v = 1'b1; e.x = x; e.y = y; e.sd = 32'h0;
        e.sel = sel; e.dest = dest; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br;
        e.chk_data = 1'b1; e.chk_sd = 1'b0;
        exp_q.push_back(e);
        last_e = e;
    endtask

    task automatic exp_ctl(input string n, input logic v, input bit is_reset);
        exp_t e;
        e.due = cyc + 1; e.name = n; e.v = v; e.x = 32'h0; e.y = 32'h0; e.sd = 32'h0;
        e.sel = 3'd7; e.dest = 5'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
        e.chk_data = is_reset; e.chk_sd = is_reset;
        exp_q.push_back(e);
        last_e = e;
    endtask

    task automatic exp_hold(input string n);
        exp_t e;
        e = last_e;
        e.due = cyc + 1;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic exp_haz(input string n, input logic val);
        haz_t h;
        h.due = cyc; h.name = n; h.val = val;
        haz_q.push_back(h);
    endtask

    // Monitor: compares every expectation that has come due on this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (haz_q.size() > 0 && haz_q[0].due <= cyc) begin
                haz_t h;
                h = haz_q.pop_front();
                total++;
                if (hazard_stall !== h.val) begin
                    bad++;
                    $display("FAIL %s: hazard_stall got %b want %b", h.name, hazard_stall, h.val);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                bit   ok;
                e = exp_q.pop_front();
                ok = (ex_valid === e.v) && (alu_sel === e.sel) && (reg_write === e.rw) &&
                     (mem_read === e.mr) && (mem_write === e.mw) && (branch === e.br);
                if (e.chk_data)
                    ok = ok && (alu_x === e.x) && (alu_y === e.y) && (dest_reg === e.dest);
                if (e.chk_sd)
                    ok = ok && (store_data === e.sd);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL %s: got v=%b x=%h y=%h sel=%0d dest=%0d rw=%b mr=%b mw=%b br=%b sd=%h | want v=%b x=%h y=%h sel=%0d dest=%0d rw=%b mr=%b mw=%b br=%b sd=%h",
                             e.name, ex_valid, alu_x, alu_y, alu_sel, dest_reg, reg_write,
                             mem_read, mem_write, branch, store_data, e.v, e.x, e.y, e.sel,
                             e.dest, e.rw, e.mr, e.mw, e.br, e.sd);
                end
            end
            if (done || cyc > 2000) begin
                if (cyc > 2000) begin
                    total++; bad++;
                    $display("FAIL timeout: cycle %0d reached, want finish before 2000", cyc);
                end
                if (exp_q.size() != 0 || haz_q.size() != 0) begin
                    total++; bad++;
                    $display("FAIL leftover: %0d output and %0d hazard expectations unchecked, want 0",
                             exp_q.size(), haz_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        step();
        exp_ctl("reset", 1'b0, 1'b1); step();
        rst = 1'b0;

        clr(); instr = I_ADDI; rt_data = 32'h123;
        exp_op("addi_se", 32'h0, 32'hFFFFFFFB, 3'd0, 5'd8, 1, 0, 0, 0); step();

        clr(); instr = I_ORI; rs_data = 32'h10;
        exp_op("ori_ze", 32'h10, 32'h00008001, 3'd3, 5'd9, 1, 0, 0, 0); step();

        clr(); instr = I_ADDF; rs_data = 32'hCC; rt_data = 32'h5;
        exm_we = 1; exm_rd = 5'd9; exm_val = 32'hAA; mwb_we = 1; mwb_rd = 5'd9; mwb_val = 32'hBB;
        exp_op("fwd_exm_prio", 32'hAA, 32'h5, 3'd0, 5'd10, 1, 0, 0, 0); step();

        clr(); instr = I_ADDF; rs_data = 32'hCC; rt_data = 32'h5;
        exm_we = 1; exm_rd = 5'd0; exm_val = 32'hAA; mwb_we = 1; mwb_rd = 5'd9; mwb_val = 32'hBB;
        exp_op("fwd_mwb_exm0", 32'hBB, 32'h5, 3'd0, 5'd10, 1, 0, 0, 0); step();

        clr(); instr = I_ADDF; rs_data = 32'hCC; rt_data = 32'h5;
        exm_we = 0; exm_rd = 5'd9; exm_val = 32'hAA; mwb_we = 1; mwb_rd = 5'd11; mwb_val = 32'h77;
        exp_op("fwd_rt_mwb_no_we", 32'hCC, 32'h77, 3'd0, 5'd10, 1, 0, 0, 0); step();

        clr(); instr = I_SUB0; rs_data = 32'h3; rt_data = 32'h4;
        exp_op("sub_rd0_norw", 32'h3, 32'h4, 3'd1, 5'd0, 0, 0, 0, 0); step();

        clr(); instr = I_MUL; rs_data = 32'h6; rt_data = 32'h7;
        exp_op("mul", 32'h6, 32'h7, 3'd5, 5'd3, 1, 0, 0, 0); step();

        clr(); instr = I_SLTI; rs_data = 32'h2;
        exp_op("slti_se", 32'h2, 32'hFFFF8000, 3'd4, 5'd3, 1, 0, 0, 0); step();

        clr(); instr = I_ANDI; rs_data = 32'h2;
        exp_op("andi_ze", 32'h2, 32'h0000FFFF, 3'd2, 5'd3, 1, 0, 0, 0); step();

        clr(); instr = I_BEQ; rs_data = 32'h11; rt_data = 32'h11;
        exp_op("beq", 32'h11, 32'h11, 3'd1, 5'd5, 0, 0, 0, 1); step();

        clr(); instr = I_BADF; exp_ctl("bad_funct_nop", 1'b1, 1'b0); step();
        clr(); instr = I_BADOP; exp_ctl("bad_op_nop", 1'b1, 1'b0); step();

        clr(); instr = I_ADDI; in_valid = 0; exp_ctl("invalid_bubble", 1'b0, 1'b0); step();

        // Load-use: lw $8 then add $10,$8,$8.
        clr(); instr = I_LW; rs_data = 32'h100;
        exp_haz("haz_lw_idle", 0);
        exp_op("lw", 32'h100, 32'h4, 3'd0, 5'd8, 1, 1, 0, 0); step();
        clr(); instr = I_ADD88;
        exp_haz("haz_loaduse", 1);
        exp_ctl("loaduse_bubble", 1'b0, 1'b0); step();
        clr(); instr = I_ADD88; mwb_we = 1; mwb_rd = 5'd8; mwb_val = 32'hDEAD;
        exp_haz("haz_after_bubble", 0);
        exp_op("add_after_load", 32'hDEAD, 32'hDEAD, 3'd0, 5'd10, 1, 0, 0, 0); step();

        // ori does not read rt, so lw $8 followed by ori $8,$1,1 is not a hazard.
        clr(); instr = I_LW; rs_data = 32'h100;
        exp_op("lw2", 32'h100, 32'h4, 3'd0, 5'd8, 1, 1, 0, 0); step();
        clr(); instr = I_ORI8; rs_data = 32'h20;
        exp_haz("haz_ori_rt_only", 0);
        exp_op("ori_after_lw", 32'h20, 32'h1, 3'd3, 5'd8, 1, 0, 0, 0); step();

        // Stall while a load-use hazard is pending: outputs hold, hazard still reported.
        clr(); instr = I_LW; rs_data = 32'h100;
        exp_op("lw3", 32'h100, 32'h4, 3'd0, 5'd8, 1, 1, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            clr(); instr = I_ADD88; stall_in = 1;
            exp_haz("haz_during_stall", 1);
            exp_hold("stall_hold_lw"); step();
        end
        clr(); instr = I_ADD88;
        exp_haz("haz_after_stall", 1);
        exp_ctl("bubble_after_stall", 1'b0, 1'b0); step();
        clr(); instr = I_ADD88; mwb_we = 1; mwb_rd = 5'd8; mwb_val = 32'hDEAD;
        exp_op("add_after_stall", 32'hDEAD, 32'hDEAD, 3'd0, 5'd10, 1, 0, 0, 0); step();

        clr(); instr = I_SW; rs_data = 32'h40; rt_data = 32'h99; flush = 1;
        exp_ctl("flush_sw", 1'b0, 1'b0); step();

        clr(); instr = I_SW; rs_data = 32'h40; rt_data = 32'h99;
        mwb_we = 1; mwb_rd = 5'd3; mwb_val = 32'h55;
        exp_op("sw_fwd_store", 32'h40, 32'h8, 3'd0, 5'd3, 0, 0, 1, 0);
        exp_q[exp_q.size()-1].sd = 32'h55;
        exp_q[exp_q.size()-1].chk_sd = 1'b1;
        last_e = exp_q[exp_q.size()-1];
        step();
        for (int i = 0; i < 3; i++) begin
            clr(); instr = I_ADDI; rs_data = 32'h1234; stall_in = 1;
            exp_hold("stall_hold_sw"); step();
        end

        clr(); instr = I_ADDI; rst = 1; stall_in = 1; flush = 1;
        exp_ctl("reset_over_stall", 1'b0, 1'b1); step();
        rst = 0;
        clr(); in_valid = 0;
        step(); step();
        done = 1'b1;
    end
endmodule
